// File: rtl/divsched_pkg.sv
// Shared definitions for the divider rate scheduler: sequencer state encoding
// and the step-index width helper.
package divsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int stepW(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/divsched_table.sv
// Step table for the rate scheduler: STEPS entries of (period, repeat), one
// synchronous write port and two asynchronous read ports.
module divsched_table
    import divsched_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int STEPS = 4,
    parameter int REPW  = 8,
    parameter int AW    = stepW(STEPS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wperiod,
    input  logic [REPW-1:0]  i_wrepeat,
    input  logic [AW-1:0]    i_raddrA,
    output logic [WIDTH-1:0] o_periodA,
    output logic [REPW-1:0]  o_repeatA,
    input  logic [AW-1:0]    i_raddrB,
    output logic [WIDTH-1:0] o_periodB,
    output logic [REPW-1:0]  o_repeatB
);

    logic [WIDTH-1:0] r_period [STEPS];
    logic [REPW-1:0]  r_repeat [STEPS];

    // Reads are combinational, so a write landing on the same edge as a read
    // is only visible from the following cycle onwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                r_period[i] <= '0;
                r_repeat[i] <= '0;
            end
        end else if (i_we) begin
            r_period[i_waddr] <= i_wperiod;
            r_repeat[i_waddr] <= i_wrepeat;
        end
    end

    assign o_periodA = r_period[i_raddrA];
    assign o_repeatA = r_repeat[i_raddrA];
    assign o_periodB = r_period[i_raddrB];
    assign o_repeatB = r_repeat[i_raddrB];

endmodule

// File: rtl/divsched.sv
// Rate scheduler: steps a clock divider through a table of (period, repeat)
// entries, counting divider matches per entry, with one-shot or looping runs.
module divsched
    import divsched_pkg::*;
#(
    parameter int         WIDTH = 25,
    parameter int         STEPS = 4,
    parameter int         REPW  = 8,
    parameter logic       DESC  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_loop,
    input  logic                      i_cfg_we,
    input  logic [stepW(STEPS)-1:0]   i_cfg_addr,
    input  logic [WIDTH-1:0]          i_cfg_period,
    input  logic [REPW-1:0]           i_cfg_repeat,
    input  logic                      i_match,
    output logic [WIDTH-1:0]          o_setup,
    output logic                      o_desc,
    output logic                      o_div_rst_n,
    output logic [stepW(STEPS)-1:0]   o_step,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int AW = stepW(STEPS);

    state_t           r_state;
    logic [WIDTH-1:0] r_setup;
    logic             r_divRstN;
    logic [AW-1:0]    r_step;
    logic             r_busy;
    logic             r_done;
    logic [REPW-1:0]  r_repCnt;

    logic [AW-1:0]    w_nextStep;
    logic [WIDTH-1:0] w_period0;
    logic [REPW-1:0]  w_repeat0;
    logic [WIDTH-1:0] w_periodNext;
    logic [REPW-1:0]  w_repeatNext;
    logic             w_lastStep;
    logic             w_endOfTable;

    // Port A always watches entry 0 (start and loop restart); port B watches
    // the step after the current one. The setup is latched on entry to LOAD
    // so the divider already sees the new period while it is held cleared.
    divsched_table #(
        .WIDTH (WIDTH),
        .STEPS (STEPS),
        .REPW  (REPW),
        .AW    (AW)
    ) u_table (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_cfg_we),
        .i_waddr   (i_cfg_addr),
        .i_wperiod (i_cfg_period),
        .i_wrepeat (i_cfg_repeat),
        .i_raddrA  ('0),
        .o_periodA (w_period0),
        .o_repeatA (w_repeat0),
        .i_raddrB  (w_nextStep),
        .o_periodB (w_periodNext),
        .o_repeatB (w_repeatNext)
    );

    assign w_nextStep   = r_step + AW'(1);
    assign w_lastStep   = (r_step == AW'(STEPS - 1));
    assign w_endOfTable = w_lastStep || (w_repeatNext == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_setup   <= '0;
            r_divRstN <= 1'b0;
            r_step    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_repCnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state   <= ST_IDLE;
                r_divRstN <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_divRstN <= 1'b0;
                        r_busy    <= 1'b0;
                        if (i_start) begin
                            r_step <= '0;
                            if (w_repeat0 == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= ST_LOAD;
                                r_busy   <= 1'b1;
                                r_setup  <= w_period0;
                                r_repCnt <= w_repeat0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        r_state   <= ST_RUN;
                        r_divRstN <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                    ST_RUN: begin
                        if (i_match) begin
                            if (r_repCnt == REPW'(1)) begin
                                r_divRstN <= 1'b0;
                                if (!w_endOfTable) begin
                                    r_state  <= ST_LOAD;
                                    r_step   <= w_nextStep;
                                    r_setup  <= w_periodNext;
                                    r_repCnt <= w_repeatNext;
                                end else if (i_loop && (w_repeat0 != '0)) begin
                                    r_state  <= ST_LOAD;
                                    r_step   <= '0;
                                    r_setup  <= w_period0;
                                    r_repCnt <= w_repeat0;
                                end else begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_repCnt <= r_repCnt - REPW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state   <= ST_IDLE;
                        r_divRstN <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_setup     = r_setup;
    assign o_desc      = DESC;
    assign o_div_rst_n = r_divRstN;
    assign o_step      = r_step;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_divsched.sv
// Self-checking bench for divsched: directed scenarios plus a random phase,
// compared every cycle against a behavioural model of the step sequence.
module tb_divsched;
    import divsched_pkg::*;

    localparam int WIDTH = 25;
    localparam int STEPS = 4;
    localparam int REPW  = 8;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rstN = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loopEn = 1'b0;
    logic             cfgWe = 1'b0;
    logic [AW-1:0]    cfgAddr = '0;
    logic [WIDTH-1:0] cfgPeriod = '0;
    logic [REPW-1:0]  cfgRepeat = '0;
    logic             match = 1'b0;
    logic [WIDTH-1:0] setup;
    logic             desc;
    logic             divRstN;
    logic [AW-1:0]    step;
    logic             busy;
    logic             done;

    int nChecks = 0;
    int nFail   = 0;

    // Model: what the scheduler should be doing, tracked as plain facts.
    logic [WIDTH-1:0] mPer [STEPS];
    logic [REPW-1:0]  mRep [STEPS];
    logic [WIDTH-1:0] mSetup;
    int               mStep;
    int               mLeft;
    bit               mActive;
    bit               mLoading;
    bit               mDivRel;
    bit               mDonePulse;

    divsched #(
        .WIDTH (WIDTH),
        .STEPS (STEPS),
        .REPW  (REPW),
        .DESC  (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_start      (start),
        .i_stop       (stop),
        .i_loop       (loopEn),
        .i_cfg_we     (cfgWe),
        .i_cfg_addr   (cfgAddr),
        .i_cfg_period (cfgPeriod),
        .i_cfg_repeat (cfgRepeat),
        .i_match      (match),
        .o_setup      (setup),
        .o_desc       (desc),
        .o_div_rst_n  (divRstN),
        .o_step       (step),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelClear();
        for (int i = 0; i < STEPS; i++) begin
            mPer[i] = '0;
            mRep[i] = '0;
        end
        mSetup = '0; mStep = 0; mLeft = 0;
        mActive = 0; mLoading = 0; mDivRel = 0; mDonePulse = 0;
    endtask

    task automatic enterStep(input int k);
        mStep    = k;
        mSetup   = mPer[k];
        mLeft    = int'(mRep[k]);
        mActive  = 1;
        mLoading = 1;
        mDivRel  = 0;
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic modelEdge();
        bit newDone;
        int nxt;
        newDone = 0;
        if (stop) begin
            mActive = 0; mLoading = 0; mDivRel = 0;
        end else if (mDonePulse) begin
            newDone = 0;
        end else if (!mActive) begin
            if (start) begin
                mStep = 0;
                if (mRep[0] == 0) newDone = 1;
                else enterStep(0);
            end
        end else if (mLoading) begin
            mLoading = 0;
            mDivRel  = 1;
        end else if (match) begin
            mLeft--;
            if (mLeft == 0) begin
                nxt = mStep + 1;
                if (nxt < STEPS && mRep[nxt] != 0) enterStep(nxt);
                else if (loopEn && mRep[0] != 0) enterStep(0);
                else begin
                    mActive = 0; mDivRel = 0; newDone = 1;
                end
            end
        end
        mDonePulse = newDone;
        if (cfgWe) begin
            mPer[cfgAddr] = cfgPeriod;
            mRep[cfgAddr] = cfgRepeat;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [30:0] obs;
        logic [30:0] exp;
        obs = {setup, step, busy, done, divRstN, desc};
        exp = {mSetup, AW'(mStep), mActive, mDonePulse, mDivRel, 1'b1};
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic st, input logic m, input logic we,
                                 input logic [AW-1:0] a, input logic [WIDTH-1:0] p,
                                 input logic [REPW-1:0] r, input string tag);
        start = s; stop = st; match = m; cfgWe = we;
        cfgAddr = a; cfgPeriod = p; cfgRepeat = r;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
        start = 0; stop = 0; match = 0; cfgWe = 0;
    endtask

    task automatic tick(input logic m, input string tag);
        applyStimulus(1'b0, 1'b0, m, 1'b0, '0, '0, '0, tag);
    endtask

    task automatic writeEntry(input logic [AW-1:0] a, input logic [WIDTH-1:0] p, input logic [REPW-1:0] r);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, a, p, r, "cfg_write");
    endtask

    // Assert reset mid-cycle, check outputs at once and across an edge, release.
    task automatic doAsyncReset(input string tag);
        start = 0; stop = 0; match = 0; cfgWe = 0;
        #2 rstN = 1'b0;
        #1;
        modelClear();
        checkOutput({tag, "_immediate"});
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"});
        #2 rstN = 1'b1;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput({tag, "_released"});
    endtask

    initial begin
        int doneCount;
        int matchCount;
        bit sawTwenty;
        modelClear();
        #6;

        $display("[TB] reset and idle");
        doAsyncReset("power_up");
        for (int i = 0; i < 4; i++) tick(1'b1, "idle_match");

        $display("[TB] one-shot sequence");
        loopEn = 0;
        writeEntry(2'd0, 25'd9, 8'd2);
        writeEntry(2'd1, 25'd4, 8'd3);
        writeEntry(2'd2, 25'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "oneshot_start");
        doneCount = 0;
        for (int c = 0; c < 70; c++) begin
            tick((c % 10) == 9, "oneshot_run");
            if (done) doneCount++;
        end
        checkValue("oneshot_done_count", doneCount, 1);
        checkValue("oneshot_final_step", step, 1);
        checkValue("oneshot_final_busy", busy, 0);

        $display("[TB] looping full table");
        writeEntry(2'd0, 25'd3, 8'd1);
        writeEntry(2'd1, 25'd5, 8'd1);
        writeEntry(2'd2, 25'd7, 8'd1);
        writeEntry(2'd3, 25'd11, 8'd1);
        loopEn = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "loop_start");
        doneCount = 0;
        matchCount = 0;
        for (int c = 0; c < 60; c++) begin
            if (matchCount == 7) loopEn = 0;
            tick((c % 4) == 3, "loop_run");
            if ((c % 4) == 3) matchCount++;
            if (done) doneCount++;
        end
        checkValue("loop_done_count", doneCount, 1);
        checkValue("loop_final_step", step, 3);

        $display("[TB] stop/start collisions");
        writeEntry(2'd0, 25'd6, 8'd1);
        writeEntry(2'd1, 25'd0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, "stop_start_idle");
        checkValue("stop_start_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "coll_start");
        tick(1'b0, "coll_load");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, '0, "stop_last_match");
        checkValue("stop_last_match_done", done, 0);
        tick(1'b0, "after_stop");
        tick(1'b0, "after_stop");

        $display("[TB] live reconfiguration");
        loopEn = 1;
        writeEntry(2'd0, 25'd9, 8'd3);
        writeEntry(2'd1, 25'd5, 8'd1);
        writeEntry(2'd2, 25'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "live_start");
        sawTwenty = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 6)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 25'd20, 8'd1, "live_write");
            else
                tick((c % 5) == 4, "live_run");
            if (setup == 25'd20 && step == 2'd0) sawTwenty = 1;
        end
        checkValue("live_new_period_seen", 32'(sawTwenty), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, "live_stop");
        loopEn = 0;

        $display("[TB] empty table start");
        writeEntry(2'd0, 25'd8, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "rep0_start");
        checkValue("rep0_done", done, 1);
        checkValue("rep0_div_held", divRstN, 0);
        tick(1'b1, "rep0_after");

        $display("[TB] random phase");
        for (int c = 0; c < 1500; c++) begin
            logic s, st, m, we;
            logic [REPW-1:0] r;
            if ($urandom_range(0, 31) == 0) loopEn = ~loopEn;
            s  = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 63) == 0);
            m  = ($urandom_range(0, 3) == 0);
            we = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            applyStimulus(s, st, m, we, 2'($urandom_range(0, 3)),
                          25'($urandom), r, "random");
        end

        $display("[TB] async reset in run");
        loopEn = 0;
        writeEntry(2'd0, 25'd7, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "rst_run_start");
        tick(1'b0, "rst_run_load");
        tick(1'b1, "rst_run_run");
        doAsyncReset("mid_run");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, "post_reset_start");
        checkValue("post_reset_done", done, 1);
        tick(1'b0, "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
